// File: rtl/data_c_pipe_intc_s2m_with_id.sv
// Single-slave to NUM-master demultiplexer: each beat is routed to m00[sid]
// through a registered output stage plus one skid entry; out-of-range IDs are dropped and counted.
module data_c_pipe_intc_s2m_with_id #(
    parameter int NUM    = 8,
    parameter int IDSIZE = 3,
    parameter int DSIZE  = 32
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [IDSIZE-1:0]   sid,
    input  logic [DSIZE-1:0]    s00_data,
    input  logic                s00_valid,
    output logic                s00_ready,
    output logic [DSIZE-1:0]    m00_data,
    output logic [NUM-1:0]      m00_valid,
    input  logic [NUM-1:0]      m00_ready,
    output logic                err_id,
    output logic [15:0]         drop_cnt
);

    localparam logic [IDSIZE:0] NUM_W = (IDSIZE+1)'(NUM);

    logic                out_vld_q, out_vld_d;
    logic [IDSIZE-1:0]   out_id_q, out_id_d;
    logic [DSIZE-1:0]    out_data_q, out_data_d;
    logic                skd_vld_q, skd_vld_d;
    logic [IDSIZE-1:0]   skd_id_q, skd_id_d;
    logic [DSIZE-1:0]    skd_data_q, skd_data_d;
    logic                s00_ready_q, s00_ready_d;
    logic                err_id_q, err_id_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                sel_rdy_s;
    logic                ohs_s;
    logic                ihs_s;
    logic                bad_id_s;
    logic                good_s;

    // Ready of the port addressed by the beat currently in the output register
    always_comb begin
        sel_rdy_s = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (out_id_q == IDSIZE'(k)) begin
                sel_rdy_s = m00_ready[k];
            end else begin
                sel_rdy_s = sel_rdy_s;
            end
        end
    end

    assign ohs_s    = out_vld_q && sel_rdy_s;
    assign ihs_s    = s00_valid && s00_ready_q;
    assign bad_id_s = ({1'b0, sid} >= NUM_W);
    assign good_s   = ihs_s && !bad_id_s;

    // Next state of the output/skid pair; the skid always drains before a new input can reach out
    always_comb begin
        out_vld_d  = out_vld_q;
        out_id_d   = out_id_q;
        out_data_d = out_data_q;
        skd_vld_d  = skd_vld_q;
        skd_id_d   = skd_id_q;
        skd_data_d = skd_data_q;
        if (!out_vld_q || ohs_s) begin
            if (skd_vld_q) begin
                out_vld_d  = 1'b1;
                out_id_d   = skd_id_q;
                out_data_d = skd_data_q;
                skd_vld_d  = good_s;
                if (good_s) begin
                    skd_id_d   = sid;
                    skd_data_d = s00_data;
                end else begin
                    skd_id_d   = skd_id_q;
                    skd_data_d = skd_data_q;
                end
            end else if (good_s) begin
                out_vld_d  = 1'b1;
                out_id_d   = sid;
                out_data_d = s00_data;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (good_s) begin
            skd_vld_d  = 1'b1;
            skd_id_d   = sid;
            skd_data_d = s00_data;
        end else begin
            skd_vld_d  = skd_vld_q;
        end
    end

    // Ready, drop pulse and saturating drop counter
    always_comb begin
        s00_ready_d = !skd_vld_d;
        err_id_d    = ihs_s && bad_id_s;
        if (err_id_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q   <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            skd_vld_q   <= 1'b0;
            skd_id_q    <= '0;
            skd_data_q  <= '0;
            s00_ready_q <= 1'b0;
            err_id_q    <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            skd_vld_q   <= skd_vld_d;
            skd_id_q    <= skd_id_d;
            skd_data_q  <= skd_data_d;
            s00_ready_q <= s00_ready_d;
            err_id_q    <= err_id_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Port valids decoded from the registered head beat
    always_comb begin
        m00_valid = '0;
        for (int k = 0; k < NUM; k++) begin
            m00_valid[k] = out_vld_q && (out_id_q == IDSIZE'(k));
        end
    end

    assign m00_data  = out_data_q;
    assign s00_ready = s00_ready_q;
    assign err_id    = err_id_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_data_c_pipe_intc_s2m_with_id.sv
// Randomised and directed bench for the ID demultiplexer, checked against an
// in-order queue model of the two-entry pipeline.
module tb_data_c_pipe_intc_s2m_with_id;

    localparam int NUM    = 6;
    localparam int IDSIZE = 3;
    localparam int DSIZE  = 16;

    logic                clock = 1'b0;
    logic                rst_n;
    logic [IDSIZE-1:0]   sid;
    logic [DSIZE-1:0]    s_data;
    logic                s_valid;
    logic                s_ready;
    logic [DSIZE-1:0]    m_data;
    logic [NUM-1:0]      m_valid;
    logic [NUM-1:0]      m_ready;
    logic                err_id;
    logic [15:0]         drop_cnt;

    data_c_pipe_intc_s2m_with_id #(.NUM(NUM), .IDSIZE(IDSIZE), .DSIZE(DSIZE)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .sid       (sid),
        .s00_data  (s_data),
        .s00_valid (s_valid),
        .s00_ready (s_ready),
        .m00_data  (m_data),
        .m00_valid (m_valid),
        .m00_ready (m_ready),
        .err_id    (err_id),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IDSIZE-1:0] id;
        logic [DSIZE-1:0]  data;
    } beat_t;

    beat_t q[$];
    bit    mdl_rdy;
    bit    mdl_err;
    int    mdl_cnt;
    int    errors = 0;
    int    checks = 0;

    function automatic logic [NUM-1:0] exp_valid();
        logic [NUM-1:0] v;
        v = '0;
        if (q.size() > 0) v[q[0].id] = 1'b1;
        return v;
    endfunction

    // Advance one clock edge and apply the transfer rules to the model
    task automatic tick();
        bit ohs, ihs;
        ohs = (q.size() > 0) && (m_ready[q[0].id] == 1'b1);
        ihs = s_valid && mdl_rdy;
        @(posedge clock);
        #1;
        if (ohs) void'(q.pop_front());
        mdl_err = 1'b0;
        if (ihs) begin
            if (int'(sid) >= NUM) begin
                mdl_err = 1'b1;
                if (mdl_cnt < 65535) mdl_cnt++;
            end else begin
                q.push_back('{sid, s_data});
            end
        end
        mdl_rdy = (q.size() < 2);
    endtask

    task automatic model_reset();
        q.delete();
        mdl_rdy = 1'b0;
        mdl_err = 1'b0;
        mdl_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; sid = '0; s_data = '0; m_ready = '1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", s_ready); end
        checks++; if (m_valid !== '0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err_id); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", drop_cnt); end
        rst_n = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%0b exp=1", s_ready); end
    endtask

    task automatic test_stream();
        logic [NUM-1:0] ev;
        m_ready = '1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; sid = IDSIZE'(i % NUM); s_data = DSIZE'(i);
            tick();
            ev = '0; ev[i % NUM] = 1'b1;
            checks++; if (m_valid !== ev) begin errors++; $display("FAIL stream_valid beat=%0d got=%b exp=%b", i, m_valid, ev); end
            checks++; if (m_data !== DSIZE'(i)) begin errors++; $display("FAIL stream_data beat=%0d got=%0h exp=%0h", i, m_data, i); end
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat=%0d got=%0b exp=1", i, s_ready); end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== '0) begin errors++; $display("FAIL stream_idle got=%b exp=0", m_valid); end
    endtask

    task automatic test_hol_stall();
        m_ready = '1; m_ready[2] = 1'b0;
        s_valid = 1'b1; sid = 3'd2; s_data = 16'hA0A0;
        tick();
        sid = 3'd5; s_data = 16'hB0B0;
        tick();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hol_ready got=%0b exp=0", s_ready); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (m_valid !== 6'b000100 || m_data !== 16'hA0A0) begin
                errors++; $display("FAIL hol_hold cyc=%0d got=%b/%0h exp=000100/a0a0", c, m_valid, m_data);
            end
            tick();
        end
        m_ready[2] = 1'b1;
        tick();
        checks++; if (m_valid !== 6'b100000 || m_data !== 16'hB0B0) begin
            errors++; $display("FAIL hol_b got=%b/%0h exp=100000/b0b0", m_valid, m_data);
        end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hol_recover got=%0b exp=1", s_ready); end
        tick();
        checks++; if (m_valid !== '0) begin errors++; $display("FAIL hol_idle got=%b exp=0", m_valid); end
    endtask

    task automatic test_bad_id();
        m_ready = '1;
        s_valid = 1'b1; sid = 3'd1; s_data = 16'h1111;
        tick();
        sid = 3'd7; s_data = 16'hDEAD;
        tick();
        checks++; if (m_valid !== '0) begin errors++; $display("FAIL bad_valid got=%b exp=0", m_valid); end
        checks++; if (err_id !== 1'b1) begin errors++; $display("FAIL bad_err got=%0b exp=1", err_id); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bad_cnt got=%0h exp=1", drop_cnt); end
        sid = 3'd3; s_data = 16'h3333;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 6'b001000 || m_data !== 16'h3333) begin
            errors++; $display("FAIL bad_next got=%b/%0h exp=001000/3333", m_valid, m_data);
        end
        checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL bad_once got=%0b exp=0", err_id); end
        tick();
    endtask

    task automatic test_saturation();
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        mdl_cnt = 65534;
        s_valid = 1'b1; sid = 3'd6; s_data = 16'h0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (err_id !== 1'b1) begin errors++; $display("FAIL sat_err drop=%0d got=%0b exp=1", i, err_id); end
            checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt drop=%0d got=%0h exp=ffff", i, drop_cnt); end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (err_id !== 1'b0) begin errors++; $display("FAIL sat_end got=%0b exp=0", err_id); end
    endtask

    task automatic test_random();
        int accepted;
        int cyc;
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            s_valid = ($urandom_range(0, 3) != 0);
            sid     = ($urandom_range(0, 49) == 0) ? IDSIZE'($urandom_range(NUM, 7)) : IDSIZE'($urandom_range(0, NUM-1));
            s_data  = DSIZE'($urandom);
            for (int k = 0; k < NUM; k++) m_ready[k] = ($urandom_range(0, 9) < 7);
            checks++; if (m_valid !== exp_valid()) begin
                errors++; if (errors < 30) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_valid());
            end
            if (q.size() > 0) begin
                checks++; if (m_data !== q[0].data) begin
                    errors++; if (errors < 30) $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", cyc, m_data, q[0].data);
                end
            end
            checks++; if (s_ready !== mdl_rdy) begin
                errors++; if (errors < 30) $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, s_ready, mdl_rdy);
            end
            checks++; if (err_id !== mdl_err || drop_cnt !== 16'(mdl_cnt)) begin
                errors++; if (errors < 30) $display("FAIL rnd_drop cyc=%0d got=%0b/%0h exp=%0b/%0h", cyc, err_id, drop_cnt, mdl_err, mdl_cnt);
            end
            if (s_valid && mdl_rdy && int'(sid) < NUM) accepted++;
            tick();
            cyc++;
        end
        checks++; if (accepted < 10000) begin errors++; $display("FAIL rnd_budget got=%0d exp=10000", accepted); end
        s_valid = 1'b0; m_ready = '1;
        repeat (3) tick();
        checks++; if (q.size() != 0 || m_valid !== '0) begin
            errors++; $display("FAIL rnd_drain got=%b/%0d exp=0/0", m_valid, q.size());
        end
    endtask

    task automatic test_reset_mid();
        m_ready = '0;
        s_valid = 1'b1; sid = 3'd0; s_data = 16'h0001;
        tick();
        sid = 3'd1; s_data = 16'h0002;
        tick();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got=%0b exp=0", s_ready); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (m_valid !== '0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%0b exp=0", s_ready); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got=%0h exp=0", drop_cnt); end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        m_ready = '1;
        tick();
        s_valid = 1'b1; sid = 3'd4; s_data = 16'h4444;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 6'b010000 || m_data !== 16'h4444) begin
            errors++; $display("FAIL rmid_first got=%b/%0h exp=010000/4444", m_valid, m_data);
        end
        tick();
        checks++; if (m_valid !== '0) begin errors++; $display("FAIL rmid_idle got=%b exp=0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hol_stall();
        test_bad_id();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
